// File: rtl/count_sequencer.sv
// count_sequencer: run controller for the shared loadable up-counter datapath.
// Accepts a run command over valid/ready, loads the counter, paces increments
// through a prescaler and stops (one-shot) or reloads (wrap mode) at the limit.
module count_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [WIDTH-1:0]      start_value,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  mode_wrap,
    input  logic                  abort,
    output logic                  cnt_load,
    output logic [WIDTH-1:0]      cnt_load_value,
    output logic                  cnt_inc,
    input  logic [WIDTH-1:0]      cnt_value,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            wrap_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [PRESCALE_W-1:0] pcnt, pcnt_next;
    logic [7:0]            wrap_cnt_q, wrap_cnt_next;

    // Command fields captured on accept; the live inputs are ignored mid-run.
    logic [WIDTH-1:0]      cap_start;
    logic [WIDTH-1:0]      cap_limit;
    logic [PRESCALE_W-1:0] cap_prescale;
    logic                  cap_wrap;

    logic accept;
    logic aborting;
    logic tick;
    logic at_limit;

    assign start_ready    = (state == S_IDLE) && !rst;
    assign accept         = start_valid && start_ready;
    assign aborting       = abort && (state != S_IDLE);
    assign tick           = (pcnt == cap_prescale);
    assign at_limit       = (cnt_value == cap_limit);
    assign busy           = (state != S_IDLE);
    assign cnt_load_value = cap_start;
    assign wrap_count     = wrap_cnt_q;

    // State register, prescale counter, wrap counter and command capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the capture registers are reset too, so cnt_load_value reads 0 out of reset.
            state        <= S_IDLE;
            pcnt         <= '0;
            wrap_cnt_q   <= '0;
            cap_start    <= '0;
            cap_limit    <= '0;
            cap_prescale <= '0;
            cap_wrap     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            pcnt       <= pcnt_next;
            wrap_cnt_q <= wrap_cnt_next;
            if (accept) begin
                cap_start    <= start_value;
                cap_limit    <= limit;
                cap_prescale <= prescale;
                cap_wrap     <= mode_wrap;
            end
        end
    end

    // Next-state, prescaler and datapath strobes; abort overrides the tick decision.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_next    = state;
        pcnt_next     = pcnt;
        wrap_cnt_next = wrap_cnt_q;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next    = S_LOAD;
                    wrap_cnt_next = '0;
                end
            end
            S_LOAD: begin
                cnt_load   = 1'b1;
                pcnt_next  = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (!tick) begin
                    pcnt_next = pcnt + 1'b1;
                end else begin
                    pcnt_next = '0;
                    if (!at_limit) begin
                        cnt_inc = 1'b1;
                    end else if (cap_wrap) begin
                        wrap_cnt_next = wrap_cnt_q + 8'd1;
                        state_next    = S_LOAD;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort gates the strobes in the same cycle and keeps the wrap count.
        if (aborting) begin
            state_next    = S_IDLE;
            pcnt_next     = '0;
            wrap_cnt_next = wrap_cnt_q;
            cnt_load      = 1'b0;
            cnt_inc       = 1'b0;
            done          = 1'b0;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with a registered counter model.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] start_value = '0;
    logic [7:0] limit = '0;
    logic [7:0] prescale = '0;
    logic       mode_wrap = 1'b0;
    logic       abort = 1'b0;
    logic       cnt_load;
    logic [7:0] cnt_load_value;
    logic       cnt_inc;
    logic [7:0] cnt_value;
    logic       busy;
    logic       done;
    logic [7:0] wrap_count;

    logic [7:0] model_cnt = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] start;
        logic [7:0] lim;
        logic [7:0] pre;
        int         incs;
        int         first_inc;
        int         done_cyc;
        int         idle_cyc;
        logic [7:0] final_cnt;
    } vec_t;

    vec_t vecs[5];

    int incs, first_inc, done_cyc, idle_cyc, load_cyc, dones, overlap;

    always #5 clk = ~clk;

    // Datapath model: registered counter with load priority over increment.
    always_ff @(posedge clk) begin
        if (cnt_load)
            model_cnt <= cnt_load_value;
        else if (cnt_inc)
            model_cnt <= model_cnt + 8'd1;
    end
    assign cnt_value = model_cnt;

    count_sequencer #(.WIDTH(8), .PRESCALE_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .start_value    (start_value),
        .limit          (limit),
        .prescale       (prescale),
        .mode_wrap      (mode_wrap),
        .abort          (abort),
        .cnt_load       (cnt_load),
        .cnt_load_value (cnt_load_value),
        .cnt_inc        (cnt_inc),
        .cnt_value      (cnt_value),
        .busy           (busy),
        .done           (done),
        .wrap_count     (wrap_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Present a command at a falling edge; it is accepted at the next rising edge (edge N).
    // Afterwards the inputs are scrambled so any late sampling shows up.
    task automatic issue(input logic [7:0] s, input logic [7:0] l, input logic [7:0] p,
                         input logic w);
        @(negedge clk);
        start_value = s;
        limit       = l;
        prescale    = p;
        mode_wrap   = w;
        start_valid = 1'b1;
        check("ready_before_accept", start_ready, 1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        start_value = ~s;
        limit       = ~l;
        prescale    = 8'd7;
        mode_wrap   = ~w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{start: 8'd3,   lim: 8'd6, pre: 8'd0, incs: 3, first_inc: 2, done_cyc: 6,  idle_cyc: 7,  final_cnt: 8'd6};
        vecs[1] = '{start: 8'd0,   lim: 8'd2, pre: 8'd3, incs: 2, first_inc: 5, done_cyc: 14, idle_cyc: 15, final_cnt: 8'd2};
        vecs[2] = '{start: 8'd250, lim: 8'd2, pre: 8'd0, incs: 8, first_inc: 2, done_cyc: 11, idle_cyc: 12, final_cnt: 8'd2};
        vecs[3] = '{start: 8'd5,   lim: 8'd5, pre: 8'd1, incs: 0, first_inc: 0, done_cyc: 4,  idle_cyc: 5,  final_cnt: 8'd5};
        vecs[4] = '{start: 8'd7,   lim: 8'd9, pre: 8'd1, incs: 2, first_inc: 3, done_cyc: 8,  idle_cyc: 9,  final_cnt: 8'd9};

        // Reset values while rst is held.
        #1 rst = 1'b1;
        #2;
        check("rst_ready",      start_ready,    0);
        check("rst_busy",       busy,           0);
        check("rst_done",       done,           0);
        check("rst_load",       cnt_load,       0);
        check("rst_inc",        cnt_inc,        0);
        check("rst_load_value", cnt_load_value, 0);
        check("rst_wrap_count", wrap_count,     0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", start_ready, 1);

        // One-shot runs from the vector table.
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].start, vecs[v].lim, vecs[v].pre, 1'b0);
            incs = 0; first_inc = 0; done_cyc = 0; idle_cyc = 0;
            load_cyc = 0; dones = 0; overlap = 0;
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (cnt_inc) begin
                    incs++;
                    if (first_inc == 0) first_inc = k;
                end
                if (cnt_load && load_cyc == 0) load_cyc = k;
                if (cnt_load && cnt_inc) overlap++;
                if (done) begin
                    dones++;
                    done_cyc = k;
                end
                if (!busy) begin
                    idle_cyc = k;
                    break;
                end
            end
            check($sformatf("v%0d_load_cycle", v), load_cyc,    1);
            check($sformatf("v%0d_inc_count", v),  incs,        vecs[v].incs);
            check($sformatf("v%0d_first_inc", v),  first_inc,   vecs[v].first_inc);
            check($sformatf("v%0d_done_cycle", v), done_cyc,    vecs[v].done_cyc);
            check($sformatf("v%0d_done_count", v), dones,       1);
            check($sformatf("v%0d_idle_cycle", v), idle_cyc,    vecs[v].idle_cyc);
            check($sformatf("v%0d_final_cnt", v),  model_cnt,   vecs[v].final_cnt);
            check($sformatf("v%0d_overlap", v),    overlap,     0);
            check($sformatf("v%0d_ready_idle", v), start_ready, 1);
            check($sformatf("v%0d_wrap_count", v), wrap_count,  0);
        end

        // Wrap mode with start_valid held high while busy; abort on an increment tick.
        issue(8'd1, 8'd3, 8'd0, 1'b1);
        start_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k >= 2)
                check($sformatf("wrap_cnt_k%0d", k), model_cnt,
                      (((k - 2) % 4) == 0) ? 1 : (((k - 2) % 4) == 1) ? 2 : 3);
            check($sformatf("wrap_count_k%0d", k), wrap_count, (k - 1) / 4);
            check($sformatf("wrap_done_k%0d", k),  done,        0);
            check($sformatf("wrap_ready_k%0d", k), start_ready, 0);
        end
        @(negedge clk);
        check("pre_abort_inc", cnt_inc, 1);
        start_valid = 1'b0;
        abort = 1'b1;
        #1;
        check("abort_gates_inc",  cnt_inc,  0);
        check("abort_gates_load", cnt_load, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy",       busy,        0);
        check("abort_ready",      start_ready, 1);
        check("abort_done",       done,        0);
        check("abort_wrap_held",  wrap_count,  4);
        check("abort_cnt_held",   model_cnt,   1);

        // Abort asserted in IDLE does not block the accept; it then kills LOAD.
        abort = 1'b1;
        issue(8'd9, 8'd20, 8'd0, 1'b0);
        @(negedge clk);
        check("idle_abort_accept", busy,       1);
        check("load_abort_gate",   cnt_load,   0);
        check("accept_clears_wrap", wrap_count, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("load_abort_idle",  busy,      0);
        check("load_abort_cnt",   model_cnt, 1);

        // Reset asserted mid-run.
        issue(8'd0, 8'd100, 8'd0, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_rst_inc", cnt_inc,   1);
        check("pre_rst_cnt", model_cnt, 3);
        rst = 1'b1;
        #1;
        check("rst_mid_busy",  busy,           0);
        check("rst_mid_inc",   cnt_inc,        0);
        check("rst_mid_ready", start_ready,    0);
        check("rst_mid_value", cnt_load_value, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_ready", start_ready, 1);
        check("rst_rel_cnt",   model_cnt,   3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
